// File: rtl/quant_pkg.sv
// rtl/quant_pkg.sv - shared types, defaults and rounding helper for the quantizer stage
package quant_pkg;

    localparam int BLK_LEN_DEF = 64;
    localparam int OUT_W_DEF   = 12;

    typedef logic signed [OUT_W_DEF-1:0] coef_t;
    typedef logic [5:0]                  idx_t;

    // Round half away from zero, then drop frac fractional bits.
    // Worked in 64 bits so the bias add can never overflow for any product width in use.
    function automatic logic signed [63:0] round_half_away(input logic signed [63:0] x,
                                                           input int frac);
        logic signed [63:0] bias;
        bias = 64'sd1 <<< (frac - 1);
        if (x < 0) begin
            bias = bias - 64'sd1;
        end
        return (x + bias) >>> frac;
    endfunction

endpackage

// File: rtl/sat_clip.sv
// rtl/sat_clip.sv - combinational signed clip from IN_W to OUT_W bits
module sat_clip #(
    parameter int IN_W  = 18,
    parameter int OUT_W = 12
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    sat
);

    localparam logic signed [IN_W-1:0] MAX_V = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W-1:0] MIN_V = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // Pass through in range, otherwise pin to the nearest representable bound.
    always_comb begin
        dout = din[OUT_W-1:0];
        sat  = 1'b0;
        if (din > MAX_V) begin
            dout = MAX_V[OUT_W-1:0];
            sat  = 1'b1;
        end else if (din < MIN_V) begin
            dout = MIN_V[OUT_W-1:0];
            sat  = 1'b1;
        end
    end

endmodule

// File: rtl/quant_round_stage.sv
// rtl/quant_round_stage.sv - round, saturate and block-tag coefficients in a two-stage pipeline
module quant_round_stage
    import quant_pkg::*;
#(
    parameter int IN_W    = 32,
    parameter int FRAC    = 15,
    parameter int OUT_W   = OUT_W_DEF,
    parameter int BLK_LEN = BLK_LEN_DEF,
    parameter int SATC_W  = 7
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clr,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [IN_W-1:0]       in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [OUT_W-1:0]      out_data,
    output logic [$clog2(BLK_LEN)-1:0]   out_idx,
    output logic                         out_last,
    output logic                         out_sat,
    output logic [SATC_W-1:0]            blk_sat_cnt
);

    localparam int IDX_W = $clog2(BLK_LEN);
    // Integer part of the rounded product plus one bit for the +0.5 carry.
    localparam int R_W   = IN_W - FRAC + 1;

    logic                    s1_valid;
    logic signed [R_W-1:0]   s1_r;
    logic                    s2_valid;
    logic                    s1_load;
    logic                    s2_load;
    logic                    in_fire;
    logic                    out_fire;
    logic [IDX_W-1:0]        idx;
    logic                    idx_last;
    logic [SATC_W-1:0]       acc;
    logic [SATC_W-1:0]       acc_next;
    logic signed [63:0]      r_full;
    logic                    unused_r_hi;
    logic signed [OUT_W-1:0] clip_data;
    logic                    clip_sat;

    assign r_full      = round_half_away(64'(in_data), FRAC);
    assign unused_r_hi = ^r_full[63:R_W];

    assign s2_load   = !s2_valid || out_ready;
    assign s1_load   = !s1_valid || s2_load;
    assign in_ready  = s1_load && !clr;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = s2_valid;
    assign out_fire  = s2_valid && out_ready;
    assign idx_last  = (idx == IDX_W'(BLK_LEN - 1));
    assign acc_next  = (out_sat && (acc != '1)) ? acc + 1'b1 : acc;

    sat_clip #(
        .IN_W  (R_W),
        .OUT_W (OUT_W)
    ) u_clip (
        .din  (s1_r),
        .dout (clip_data),
        .sat  (clip_sat)
    );

    // S1: capture the rounded product whenever the stage can move.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_r     <= '0;
        end else if (clr) begin
            s1_valid <= 1'b0;
        end else if (s1_load) begin
            s1_valid <= in_fire;
            if (in_fire) begin
                s1_r <= r_full[R_W-1:0];
            end
        end
    end

    // S2: clip, tag with block position and hold while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_data <= '0;
            out_idx  <= '0;
            out_last <= 1'b0;
            out_sat  <= 1'b0;
            idx      <= '0;
        end else if (clr) begin
            s2_valid <= 1'b0;
            idx      <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= clip_data;
                out_sat  <= clip_sat;
                out_idx  <= idx;
                out_last <= idx_last;
                idx      <= idx_last ? '0 : idx + 1'b1;
            end
        end
    end

    // Per-block saturation tally, published when the last coefficient of a block is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc         <= '0;
            blk_sat_cnt <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (out_fire) begin
            if (out_last) begin
                blk_sat_cnt <= acc_next;
                acc         <= '0;
            end else begin
                acc <= acc_next;
            end
        end
    end

endmodule

// File: tb/tb_quant_round_stage.sv
// tb/tb_quant_round_stage.sv - scoreboard bench for quant_round_stage
module tb_quant_round_stage;
    import quant_pkg::*;

    typedef struct {
        coef_t data;
        logic  sat;
        idx_t  idx;
        logic  last;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               clr = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [31:0] in_data = '0;
    logic               out_valid;
    logic               out_ready = 1'b1;
    coef_t              out_data;
    idx_t               out_idx;
    logic               out_last;
    logic               out_sat;
    logic [6:0]         blk_sat_cnt;

    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];
    exp_t mon_e;
    int   exp_idx = 0;
    int   mon_acc = 0;
    int   mon_blk = 0;

    quant_round_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_idx     (out_idx),
        .out_last    (out_last),
        .out_sat     (out_sat),
        .blk_sat_cnt (blk_sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic send(input logic [31:0] x, input int d, input logic s);
        exp_t e;
        int   n;
        n = 0;
        in_data  = x;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                e.data  = coef_t'(d);
                e.sat   = s;
                e.idx   = idx_t'(exp_idx);
                e.last  = (exp_idx == BLK_LEN_DEF - 1);
                sbq.push_back(e);
                exp_idx = (exp_idx + 1) % BLK_LEN_DEF;
                break;
            end
            n++;
            if (n > 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout actual=in_ready_low required=accept x=%08h", x);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic void pat(input int i, output logic [31:0] x, output int d,
                                output logic s);
        s = 1'b0;
        case (i)
            5, 63:       begin x = 32'h7FFF_FFFF; d = 2047;  s = 1'b1; end
            10, 70, 127: begin x = 32'h8000_0000; d = -2048; s = 1'b1; end
            20:          begin x = 32'h03FF_C000; d = 2047;  s = 1'b1; end
            40:          begin x = 32'hFBFF_C000; d = -2048; s = 1'b1; end
            7:           begin x = 32'h03FF_BFFF; d = 2047;  end
            8:           begin x = 32'hFC00_0000; d = -2048; end
            9:           begin x = 32'hFFFF_C001; d = 0;     end
            11:          begin x = 32'hFFFF_BFFF; d = -1;    end
            default: begin
                d = i - 65;
                x = 32'(d * 32768 + 12288);
            end
        endcase
    endfunction

    task automatic send_pat(input int i);
        logic [31:0] x;
        int          d;
        logic        s;
        pat(i, x, d, s);
        send(x, d, s);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check("drain_pending", sbq.size(), 0);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        sbq.delete();
        exp_idx = 0;
    endtask

    // Monitor: pops the expected item on every output handshake and tracks the block tally.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_acc = 0;
            mon_blk = 0;
        end else if (clr) begin
            mon_acc = 0;
        end else if (out_valid && out_ready) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output actual=%0d idx=%0d required=none", out_data, out_idx);
            end else begin
                mon_e = sbq.pop_front();
                if (out_data !== mon_e.data || out_sat !== mon_e.sat ||
                    out_idx !== mon_e.idx || out_last !== mon_e.last) begin
                    errors++;
                    $display("FAIL item actual=%0d/sat%0b/idx%0d/last%0b required=%0d/sat%0b/idx%0d/last%0b",
                             out_data, out_sat, out_idx, out_last,
                             mon_e.data, mon_e.sat, mon_e.idx, mon_e.last);
                end
                checks++;
                if (blk_sat_cnt !== 7'(mon_blk)) begin
                    errors++;
                    $display("FAIL blk_sat_cnt actual=%0d required=%0d", blk_sat_cnt, mon_blk);
                end
                if (mon_e.sat && mon_acc < 127) mon_acc++;
                if (mon_e.last) begin
                    mon_blk = mon_acc;
                    mon_acc = 0;
                end
            end
        end
    end

    initial begin
        #3;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_idx", out_idx, 0);
        check("rst_out_last", out_last, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_blk_sat_cnt", blk_sat_cnt, 0);
        #20;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", in_ready, 1);

        send(32'h0000_4000, 1, 1'b0);
        check("lat_not_yet", out_valid, 0);
        @(posedge clk);
        #1;
        check("lat_valid", out_valid, 1);
        check("lat_data", out_data, 1);
        send(32'hFFFF_C000, -1, 1'b0);
        send(32'h0000_3FFF, 0, 1'b0);
        send(32'h7FFF_FFFF, 2047, 1'b1);
        send(32'h8000_0000, -2048, 1'b1);
        drain();
        do_clr();

        out_ready = 1'b0;
        fork
            begin
                send(32'h0000_8000, 1, 1'b0);
                send(32'h0001_0000, 2, 1'b0);
                send(32'hFFFE_8000, -3, 1'b0);
            end
            begin
                repeat (4) @(posedge clk);
                #2;
                check("bp_accepted", sbq.size(), 2);
                check("bp_in_ready", in_ready, 0);
                check("bp_out_valid", out_valid, 1);
                check("bp_out_data", out_data, 1);
                repeat (2) @(posedge clk);
                #2;
                check("bp_data_stable", out_data, 1);
                check("bp_idx_stable", out_idx, 0);
                out_ready = 1'b1;
            end
        join
        drain();

        do_clr();
        for (int i = 0; i < 130; i++) send_pat(i);
        drain();
        check("blk1_sat_cnt", blk_sat_cnt, 2);
        check("blk2_idx", out_idx, 1);

        out_ready = 1'b0;
        send(32'h0000_8000, 1, 1'b0);
        send(32'h0001_0000, 2, 1'b0);
        in_data  = 32'h0001_8000;
        in_valid = 1'b1;
        clr      = 1'b1;
        @(negedge clk);
        check("clr_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        clr      = 1'b0;
        in_valid = 1'b0;
        sbq.delete();
        exp_idx = 0;
        check("clr_out_valid", out_valid, 0);
        check("clr_keeps_blk", blk_sat_cnt, 2);
        out_ready = 1'b1;
        send(32'h0001_8000, 3, 1'b0);
        drain();

        do_clr();
        for (int i = 0; i < 17; i++) send_pat(i);
        drain();
        out_ready = 1'b0;
        send_pat(17);
        @(posedge clk);
        #1;
        check("mid_idx", out_idx, 17);
        check("mid_data", out_data, -48);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data", out_data, 0);
        check("arst_out_idx", out_idx, 0);
        check("arst_blk", blk_sat_cnt, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        sbq.delete();
        exp_idx   = 0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(32'h0000_4000, 1, 1'b0);
        drain();
        check("post_rst_blk", blk_sat_cnt, 0);
        check("post_rst_idx", out_idx, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/quant_round_stage.md
Name: quant_round_stage

Overview:
Downstream consumer of the constant-coefficient fixed-point multiplier in the DCT/quantization datapath.
- Takes signed Q(IN_W-FRAC).FRAC products, rounds half away from zero and saturates to OUT_W-bit signed coefficients.
- Tags each output with its position in an 8x8 block (64 coefficients) and counts saturations per block.
- Two-stage valid/ready pipeline that feeds the entropy/zigzag stage.

Parameters:
IN_W, 32, product width from the multiplier (signed)
FRAC, 15, fractional bits in the input product
OUT_W, 12, output coefficient width (signed)
BLK_LEN, 64, coefficients per block
SATC_W, 7, width of the per-block saturation counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous flush: empties pipeline, resets index and counters
in_valid  in  1  input product valid
in_ready  out  1  stage can accept the input
in_data  in  IN_W  signed product, FRAC fractional bits
out_valid  out  1  output coefficient valid
out_ready  in  1  downstream accepts
out_data  out  OUT_W  rounded, saturated coefficient
out_idx  out  $clog2(BLK_LEN)  coefficient index within the block
out_last  out  1  out_idx == BLK_LEN-1
out_sat  out  1  this coefficient was clipped
blk_sat_cnt  out  SATC_W  saturation count of the last completed block

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: all valids 0, out_data 0, out_idx 0, out_last 0, out_sat 0, blk_sat_cnt 0, internal idx and sat accumulator 0.
- Input handshake: in_valid && in_ready. Output handshake: out_valid && out_ready.
- Stage S1 (rounding):
  - r = (x + (x<0 ? 2^(FRAC-1)-1 : 2^(FRAC-1))) >>> FRAC.
  - Computed in IN_W+1 bits so the bias add cannot overflow.
  - Registered into S1 with s1_valid.
- Stage S2 (saturation):
  - Clip r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Set sat when clipped; attach idx.
  - Registers drive the out_* ports; out_valid = s2_valid.
- Stall rules:
  - s2_load = !s2_valid || out_ready.
  - s1_load = !s1_valid || s2_load.
  - in_ready = s1_load. The combinational path out_ready -> in_ready is allowed.
  - Data is held stable while out_valid && !out_ready.
- Latency: 2 cycles from input handshake to out_valid with no backpressure. Throughput is 1 per cycle. At most 2 items in flight.
- Index counter:
  - Assigned at S2 load, incremented per item entering S2.
  - Wraps BLK_LEN-1 -> 0. out_last asserted with the wrapping item.
- Saturation accumulator:
  - Increments for each saturated item at the output handshake; sticks at 2^SATC_W-1.
  - On the handshake of an out_last item: blk_sat_cnt <= accumulator (including the current item), and the accumulator clears to 0.
- clr:
  - Next cycle s1_valid = s2_valid = 0, idx = 0, accumulator = 0. blk_sat_cnt is retained.
  - clr wins over a simultaneous input handshake; that input is dropped, and in_ready = 0 while clr is high.
- rst_n asserted mid-block: everything returns to reset values immediately; no partial-block state survives.
- Exact boundaries:
  - x = +0.5 LSB -> +1; x = -0.5 LSB -> -1.
  - x = 2^(FRAC-1)-1 -> 0.
  - Most-negative input saturates without overflow.

Decomposition:
- Shared package quant_pkg:
  - BLK_LEN_DEF = 64, OUT_W_DEF = 12.
  - typedef coef_t (signed OUT_W), idx_t (6 bits).
  - Function round_half_away(x, FRAC) shared with the bench model.
- One natural sub-module: sat_clip (combinational signed clip, parameterised IN/OUT width) used in S2.
- Pipeline control and counters stay in the top.

Test Plan:
- FRAC=15, OUT_W=12, out_ready=1:
  - in 0x00004000 -> out 1 after 2 cycles.
  - in 0xFFFFC000 -> out -1.
  - in 0x00003FFF -> out 0.
  - All three with out_sat=0.
- Saturation: in 0x7FFFFFFF -> out 2047, out_sat=1; in 0x80000000 -> out -2048, out_sat=1.
- Backpressure: out_ready=0 for 6 cycles, in_valid=1 with 3 items -> only 2 accepted, in_ready=0 from cycle 2; out_data stable; release -> the 3 items emerge in order.
- Block framing: 130 back-to-back inputs, 5 of them saturating in block 0 -> out_last on items 63 and 127; out_idx wraps to 0; blk_sat_cnt=5 after item 63.
- clr asserted with 2 items in flight and in_valid=1 -> next cycle out_valid=0, that input not accepted; the following item emerges with out_idx=0.
- rst_n pulsed low mid-block (idx=17) -> outputs 0 asynchronously; after release the first output has idx 0 and blk_sat_cnt=0.
